// File: rtl/rxcea_pkg.sv
// Shared types and CRC-16/MODBUS helpers for the rxcea command frame parser.

package rxcea_pkg;

   typedef enum logic [2:0] {
      S_ID1,
      S_ID2,
      S_CNT1,
      S_CNT2,
      S_DATA,
      S_CRC1,
      S_CRC2
   } state_e;

   localparam logic [15:0] CRC16_INIT = 16'hFFFF;
   localparam logic [15:0] CRC16_POLY = 16'hA001;

   // Reflected CRC-16 over one byte, eight bit-steps unrolled.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
      logic [15:0] c;
      c = crc_in ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc16_modbus_byte.sv
// Combinational CRC-16/MODBUS update absorbing one byte per evaluation.

module crc16_modbus_byte
   import rxcea_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);

   assign crc_out = crc16_byte(crc_in, data);

endmodule

// File: rtl/rxcea_frame_parse.sv
// Command frame parser: ID1 ID2 CNT1 CNT2 PAYLOAD[CNT] CRC1 CRC2 -> cmd/cmd_flag or frame_err.
// Define RXCEA_CRC_CHECK_EN to build the CRC datapath and reject frames with a bad CRC.

module rxcea_frame_parse
   import rxcea_pkg::*;
#(
   parameter logic [15:0] DEV_ID      = 16'h0000,
   parameter int unsigned MAX_LEN     = 8,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] rx_data,
   input  logic       rx_data_flag,
   output logic [7:0] cmd,
   output logic       cmd_flag,
   output logic       frame_err
);

   localparam int unsigned     TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [15:0]     LEN_MAX  = 16'(MAX_LEN);

   state_e        state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   idx_q, idx_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    cmd_buf_q, cmd_buf_d;
   logic [7:0]    cmd_q, cmd_d;
   logic          cmd_flag_q, cmd_flag_d;
   logic          frame_err_q, frame_err_d;
   logic [15:0]   len_new;
   logic          crc_ok;

   assign len_new = {len_q[15:8], rx_data};

`ifdef RXCEA_CRC_CHECK_EN
   logic [15:0] crc_q, crc_d;
   logic [15:0] crc_in, crc_out;
   logic [7:0]  crc_lo_q, crc_lo_d;

   assign crc_in = (state_q == S_ID1) ? CRC16_INIT : crc_q;
   assign crc_ok = ({rx_data, crc_lo_q} == crc_q);

   crc16_modbus_byte u_crc (
      .crc_in  (crc_in),
      .data    (rx_data),
      .crc_out (crc_out)
   );

   // CRC covers ID1 through the last payload byte, then freezes for the compare.
   always_comb begin
      crc_d    = crc_q;
      crc_lo_d = crc_lo_q;
      if (state_q == S_ID1) begin
         crc_d = CRC16_INIT;
      end
      if (rx_data_flag) begin
         unique case (state_q)
            S_ID1:                         if (rx_data == DEV_ID[15:8]) crc_d = crc_out;
            S_ID2, S_CNT1, S_CNT2, S_DATA: crc_d = crc_out;
            S_CRC1:                        crc_lo_d = rx_data;
            default:                       ;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         crc_q    <= CRC16_INIT;
         crc_lo_q <= 8'h00;
      end else begin
         crc_q    <= crc_d;
         crc_lo_q <= crc_lo_d;
      end
   end
`else
   assign crc_ok = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      cmd_buf_d   = cmd_buf_q;
      cmd_d       = cmd_q;
      cmd_flag_d  = 1'b0;
      frame_err_d = 1'b0;
      tmo_d       = (rx_data_flag || state_q == S_ID1) ? '0 : tmo_q + TW'(1);

      if (rx_data_flag) begin
         unique case (state_q)
            S_ID1: begin
               if (rx_data == DEV_ID[15:8]) state_d = S_ID2;
            end
            S_ID2: begin
               state_d = (rx_data == DEV_ID[7:0]) ? S_CNT1 : S_ID1;
            end
            S_CNT1: begin
               len_d   = {rx_data, len_q[7:0]};
               state_d = S_CNT2;
            end
            S_CNT2: begin
               len_d = len_new;
               if (len_new == 16'h0000 || len_new > LEN_MAX) begin
                  frame_err_d = 1'b1;
                  state_d     = S_ID1;
               end else begin
                  idx_d   = 16'h0000;
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               if (idx_q == 16'h0000) cmd_buf_d = rx_data;
               if (idx_q == len_q - 16'd1) begin
                  state_d = S_CRC1;
               end else begin
                  idx_d = idx_q + 16'd1;
               end
            end
            S_CRC1: begin
               state_d = S_CRC2;
            end
            S_CRC2: begin
               if (crc_ok) begin
                  cmd_d      = cmd_buf_q;
                  cmd_flag_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = S_ID1;
            end
            default: state_d = S_ID1;
         endcase
      end else if (state_q != S_ID1 && tmo_q == TMO_LAST) begin
         frame_err_d = 1'b1;
         state_d     = S_ID1;
         tmo_d       = '0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= S_ID1;
         len_q       <= 16'h0000;
         idx_q       <= 16'h0000;
         tmo_q       <= '0;
         cmd_buf_q   <= 8'h00;
         cmd_q       <= 8'h00;
         cmd_flag_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         cmd_buf_q   <= cmd_buf_d;
         cmd_q       <= cmd_d;
         cmd_flag_q  <= cmd_flag_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign cmd       = cmd_q;
   assign cmd_flag  = cmd_flag_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rxcea_frame_parse.sv
// Directed self-checking bench for rxcea_frame_parse (short timeout for simulation).

module tb_rxcea_frame_parse;

   localparam int unsigned T = 40;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_data_flag = 1'b0;
   logic [7:0] cmd;
   logic       cmd_flag;
   logic       frame_err;

   int checks = 0;
   int errors = 0;
   int n_flag = 0;
   int n_err  = 0;
   int n_both = 0;
   int f0, e0;

   logic [7:0] fq[$];

   always #5 sys_clk = ~sys_clk;

   rxcea_frame_parse #(
      .DEV_ID      (16'h0000),
      .MAX_LEN     (8),
      .TIMEOUT_CYC (T)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .rx_data      (rx_data),
      .rx_data_flag (rx_data_flag),
      .cmd          (cmd),
      .cmd_flag     (cmd_flag),
      .frame_err    (frame_err)
   );

   always @(negedge sys_clk) begin
      if (cmd_flag)              n_flag <= n_flag + 1;
      if (frame_err)             n_err  <= n_err + 1;
      if (cmd_flag && frame_err) n_both <= n_both + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bit-serial reflected CRC model over the frame queue.
   function automatic logic [15:0] model_crc();
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (fq[k]) begin
         for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ fq[k][i];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
         end
      end
      return c;
   endfunction

   task automatic add_crc(input logic [7:0] lo_xor);
      logic [15:0] c;
      c = model_crc();
      fq.push_back(c[7:0] ^ lo_xor);
      fq.push_back(c[15:8]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data      = b;
      rx_data_flag = 1'b1;
      @(posedge sys_clk);
      #1;
      rx_data_flag = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic send_q(input string tag);
      for (int i = 0; i < fq.size(); i++) begin
         if (i == fq.size() - 1) begin
            check({tag, "_pre_flag"}, {31'd0, cmd_flag}, 32'd0);
            check({tag, "_pre_err"}, {31'd0, frame_err}, 32'd0);
         end
         send_byte(fq[i]);
      end
   endtask

   initial begin
      // Reset
      idle(3);
      check("rst_cmd", {24'd0, cmd}, 32'h00);
      check("rst_flag", {31'd0, cmd_flag}, 32'd0);
      check("rst_err", {31'd0, frame_err}, 32'd0);
      sys_rst = 1'b0;
      idle(2);

      // 1: valid frame
      fq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h05};
      add_crc(8'h00);
      send_q("t1");
      check("t1_flag", {31'd0, cmd_flag}, 32'd1);
      check("t1_err", {31'd0, frame_err}, 32'd0);
      check("t1_cmd", {24'd0, cmd}, 32'h05);
      idle(1);
      check("t1_flag_pulse", {31'd0, cmd_flag}, 32'd0);
      check("t1_cmd_hold", {24'd0, cmd}, 32'h05);

      // 2: corrupted CRC1
      fq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h05};
      add_crc(8'h01);
      send_q("t2");
`ifdef RXCEA_CRC_CHECK_EN
      check("t2_err", {31'd0, frame_err}, 32'd1);
      check("t2_flag", {31'd0, cmd_flag}, 32'd0);
`else
      check("t2_err", {31'd0, frame_err}, 32'd0);
      check("t2_flag", {31'd0, cmd_flag}, 32'd1);
`endif
      check("t2_cmd", {24'd0, cmd}, 32'h05);
      idle(1);
      check("t2_err_pulse", {31'd0, frame_err}, 32'd0);

      // 3: illegal CNT values, then a valid frame
      fq = '{8'h00, 8'h00, 8'h00, 8'h00};
      send_q("t3a");
      check("t3_cnt0_err", {31'd0, frame_err}, 32'd1);
      fq = '{8'h00, 8'h00, 8'h00, 8'h09};
      send_q("t3b");
      check("t3_cnt9_err", {31'd0, frame_err}, 32'd1);
      check("t3_cnt9_flag", {31'd0, cmd_flag}, 32'd0);
      fq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h3A};
      add_crc(8'h00);
      send_q("t3c");
      check("t3_flag", {31'd0, cmd_flag}, 32'd1);
      check("t3_cmd", {24'd0, cmd}, 32'h3A);
      idle(2);

      // 4: timeout after ID1 ID2 CNT1
      fq = '{8'h00, 8'h00, 8'h00};
      send_q("t4");
      e0 = n_err;
      idle(T - 1);
      check("t4_no_err_early", {31'd0, frame_err}, 32'd0);
      idle(1);
      check("t4_tmo_err", {31'd0, frame_err}, 32'd1);
      idle(1);
      check("t4_tmo_pulse", {31'd0, frame_err}, 32'd0);
      idle(3);
      check("t4_err_count", n_err - e0, 32'd1);
      // Byte on the last allowed cycle keeps the frame alive
      fq = '{8'h00, 8'h00, 8'h00};
      send_q("t4b");
      idle(T - 1);
      send_byte(8'h01);
      check("t4b_edge_err", {31'd0, frame_err}, 32'd0);
      fq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h4C};
      add_crc(8'h00);
      fq = fq[4:6];
      send_q("t4b");
      check("t4b_flag", {31'd0, cmd_flag}, 32'd1);
      check("t4b_cmd", {24'd0, cmd}, 32'h4C);
      idle(2);

      // 5: wrong device ID is ignored silently
      f0 = n_flag;
      e0 = n_err;
      fq = '{8'h12, 8'h34, 8'h00, 8'h01, 8'h07};
      add_crc(8'h00);
      foreach (fq[i]) send_byte(fq[i]);
      idle(2);
      check("t5_no_flag", n_flag - f0, 32'd0);
      check("t5_no_err", n_err - e0, 32'd0);
      fq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h07};
      add_crc(8'h00);
      send_q("t5b");
      check("t5_flag", {31'd0, cmd_flag}, 32'd1);
      check("t5_cmd", {24'd0, cmd}, 32'h07);
      idle(2);

      // 6: back-to-back MAX_LEN payload, then reset mid-frame
      fq = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
      add_crc(8'h00);
      send_q("t6");
      check("t6_flag", {31'd0, cmd_flag}, 32'd1);
      check("t6_cmd", {24'd0, cmd}, 32'h11);
      idle(2);
      e0 = n_err;
      fq = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h22};
      send_q("t6r");
      sys_rst = 1'b1;
      idle(1);
      check("t6_rst_cmd", {24'd0, cmd}, 32'h00);
      check("t6_rst_flag", {31'd0, cmd_flag}, 32'd0);
      check("t6_rst_err", {31'd0, frame_err}, 32'd0);
      sys_rst = 1'b0;
      idle(2);
      check("t6_rst_no_err", n_err - e0, 32'd0);
      fq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h5B};
      add_crc(8'h00);
      send_q("t6b");
      check("t6b_flag", {31'd0, cmd_flag}, 32'd1);
      check("t6b_cmd", {24'd0, cmd}, 32'h5B);
      idle(2);

      check("never_both", n_both, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
